// File: rtl/l2_port_arbiter_pkg.sv
// Shared types and constants for the L1-to-L2 port arbiter and the L1 caches.
package l2_port_arbiter_pkg;

    // Cache line geometry shared with the I-cache and D-cache.
    localparam int ARB_LINE_W      = 256;
    localparam int ARB_ADDR_W      = 32;
    localparam int ARB_LINE_OFFS_W = 5;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        RELEASE = 2'd3
    } arb_state_t;

    // Which requester owned the most recent grant.
    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } arb_grant_t;

    // Fair choice between two requesters: a lone requester wins outright,
    // under contention the side that was not granted last time wins.
    function automatic arb_grant_t pick_grant(
        input logic       i_req,
        input logic       d_req,
        input arb_grant_t last
    );
        arb_grant_t g;
        g = GRANT_I;
        if (i_req && d_req) begin
            g = (last == GRANT_I) ? GRANT_D : GRANT_I;
        end else if (d_req) begin
            g = GRANT_D;
        end
        return g;
    endfunction

endpackage

// File: rtl/l2_port_arbiter.sv
// Arbitrates I-cache line reads and D-cache line reads/write-backs onto a
// single memory port, one transaction at a time, alternating under contention.
//
// Handshake: each requester raises its request (i_read, or d_read/d_write)
// together with a stable address/data and holds it until the matching
// x_resp pulse. x_resp is high for exactly one cycle, coincident with
// pmem_resp, and only if the request is still held at that time; dropping
// a request early lets memory finish but suppresses the response. The
// memory side sees pmem_read/pmem_write held high from grant until
// pmem_resp, followed by one cycle with both low.
module l2_port_arbiter
    import l2_port_arbiter_pkg::*;
#(
    parameter int LINE_W = ARB_LINE_W,
    parameter int ADDR_W = ARB_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,

    // I-cache side
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,

    // D-cache side
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,

    // Memory / L2 side
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp,

    // Debug view of the FSM state
    output arb_state_t        o_state
);

    // ------------------------------------------------------------------
    // State and latched transaction
    // ------------------------------------------------------------------
    arb_state_t        r_state;
    arb_state_t        w_next_state;
    arb_grant_t        r_last_grant;
    arb_grant_t        w_pick;

    logic              r_d_write;
    logic [ADDR_W-1:0] r_addr;
    logic [LINE_W-1:0] r_wdata;

    logic              w_i_req;
    logic              w_d_req;
    logic              w_grant_i;
    logic              w_grant_d;

    assign w_i_req = i_read;
    assign w_d_req = d_read | d_write;
    assign w_pick  = pick_grant(w_i_req, w_d_req, r_last_grant);

    // A grant happens only on the IDLE->SERVE transition.
    assign w_grant_i = (r_state == IDLE) && (w_next_state == SERVE_I);
    assign w_grant_d = (r_state == IDLE) && (w_next_state == SERVE_D);

    // Next-state decode; memory responses outside SERVE_x are ignored.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_i_req || w_d_req) begin
                    w_next_state = (w_pick == GRANT_I) ? SERVE_I : SERVE_D;
                end
            end
            SERVE_I, SERVE_D: begin
                if (pmem_resp) begin
                    w_next_state = RELEASE;
                end
            end
            RELEASE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // State register; reset abandons any in-flight transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Capture the winner's address, data and op at grant so the memory port
    // stays stable even if the requester changes its inputs mid-transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= GRANT_I;
            r_d_write    <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
        end else if (w_grant_i) begin
            r_last_grant <= GRANT_I;
            r_d_write    <= 1'b0;
            r_addr       <= i_addr;
        end else if (w_grant_d) begin
            r_last_grant <= GRANT_D;
            // Write wins when both d_read and d_write are (illegally) high.
            r_d_write    <= d_write;
            r_addr       <= d_addr;
            r_wdata      <= d_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------

    // Moore memory commands: driven only from the state and the latched op,
    // so read and write can never be high together.
    always_comb begin
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        case (r_state)
            SERVE_I: pmem_read = 1'b1;
            SERVE_D: begin
                pmem_write = r_d_write;
                pmem_read  = ~r_d_write;
            end
            default: begin
                pmem_read  = 1'b0;
                pmem_write = 1'b0;
            end
        endcase
    end

    // Completion pulses follow pmem_resp combinationally, gated by the
    // requester still holding its request.
    always_comb begin
        i_resp = 1'b0;
        d_resp = 1'b0;
        if (pmem_resp) begin
            if (r_state == SERVE_I) begin
                i_resp = w_i_req;
            end
            if (r_state == SERVE_D) begin
                d_resp = w_d_req;
            end
        end
    end

    assign pmem_address = r_addr;
    assign pmem_wdata   = r_wdata;
    assign i_rdata      = pmem_rdata;
    assign d_rdata      = pmem_rdata;
    assign o_state      = r_state;

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Directed bench for l2_port_arbiter: the bench plays both caches and memory.
module tb_l2_port_arbiter;
  import l2_port_arbiter_pkg::*;

  localparam int LW = 256;
  localparam int AW = 32;

  logic          clk;
  logic          rst_n;
  logic          i_read;
  logic [AW-1:0] i_addr;
  logic [LW-1:0] i_rdata;
  logic          i_resp;
  logic          d_read;
  logic          d_write;
  logic [AW-1:0] d_addr;
  logic [LW-1:0] d_wdata;
  logic [LW-1:0] d_rdata;
  logic          d_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata;
  logic          pmem_resp;
  arb_state_t    o_state;

  int total;
  int bad;

  l2_port_arbiter #(.LINE_W(LW), .ADDR_W(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_read       (i_read),
    .i_addr       (i_addr),
    .i_rdata      (i_rdata),
    .i_resp       (i_resp),
    .d_read       (d_read),
    .d_write      (d_write),
    .d_addr       (d_addr),
    .d_wdata      (d_wdata),
    .d_rdata      (d_rdata),
    .d_resp       (d_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp),
    .o_state      (o_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // drivers: inputs change 1 time unit after the rising edge, checks at falling edge
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic sample;
    @(negedge clk);
  endtask

  task automatic clear_inputs;
    i_read = 1'b0; i_addr = '0;
    d_read = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0;
    pmem_rdata = '0; pmem_resp = 1'b0;
  endtask

  task automatic apply_reset;
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    clear_inputs();
    sample();
    total++; if (o_state !== IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=%0d", o_state, IDLE); end
    total++; if (pmem_read !== 1'b0) begin bad++; $display("FAIL reset_pmem_read got=%b exp=0", pmem_read); end
    total++; if (pmem_write !== 1'b0) begin bad++; $display("FAIL reset_pmem_write got=%b exp=0", pmem_write); end
    total++; if (i_resp !== 1'b0 || d_resp !== 1'b0) begin bad++; $display("FAIL reset_resp got=%b%b exp=00", i_resp, d_resp); end
    total++; if (pmem_address !== '0) begin bad++; $display("FAIL reset_addr got=%h exp=0", pmem_address); end
    total++; if (pmem_wdata !== '0) begin bad++; $display("FAIL reset_wdata got=%h exp=0", pmem_wdata); end
    tick();
    rst_n = 1'b1;
  endtask

  // I-cache read with 4-cycle memory latency
  task automatic test_i_read;
    logic [LW-1:0] data;
    data = {8{32'hDEADBEEF}};
    i_read = 1'b1; i_addr = 32'h0000_0040;
    sample();
    total++; if (pmem_read !== 1'b0) begin bad++; $display("FAIL iread_idle_cmd got=%b exp=0", pmem_read); end
    for (int c = 0; c < 3; c++) begin
      tick();
      sample();
      total++; if (pmem_read !== 1'b1 || pmem_write !== 1'b0) begin bad++; $display("FAIL iread_cmd c=%0d got=%b%b exp=10", c, pmem_read, pmem_write); end
      total++; if (pmem_address !== 32'h40) begin bad++; $display("FAIL iread_addr got=%h exp=00000040", pmem_address); end
      total++; if (i_resp !== 1'b0) begin bad++; $display("FAIL iread_early_resp got=%b exp=0", i_resp); end
    end
    tick();
    pmem_resp = 1'b1; pmem_rdata = data;
    sample();
    total++; if (i_resp !== 1'b1 || d_resp !== 1'b0) begin bad++; $display("FAIL iread_resp got=%b%b exp=10", i_resp, d_resp); end
    total++; if (i_rdata !== data) begin bad++; $display("FAIL iread_rdata got=%h exp=%h", i_rdata, data); end
    tick();
    pmem_resp = 1'b0; i_read = 1'b0;
    sample();
    total++; if (o_state !== RELEASE || pmem_read !== 1'b0) begin bad++; $display("FAIL iread_release got=%0d/%b exp=%0d/0", o_state, pmem_read, RELEASE); end
    total++; if (i_resp !== 1'b0) begin bad++; $display("FAIL iread_resp_width got=%b exp=0", i_resp); end
    tick();
    sample();
    total++; if (o_state !== IDLE) begin bad++; $display("FAIL iread_back_idle got=%0d exp=%0d", o_state, IDLE); end
  endtask

  // D-cache write-back, 2-cycle memory latency
  task automatic test_d_write;
    logic [LW-1:0] wd;
    wd = {32{8'hA5}};
    d_write = 1'b1; d_addr = 32'h0000_1000; d_wdata = wd;
    tick();
    sample();
    total++; if (pmem_write !== 1'b1 || pmem_read !== 1'b0) begin bad++; $display("FAIL dwr_cmd got=%b%b exp=01", pmem_read, pmem_write); end
    total++; if (pmem_address !== 32'h1000) begin bad++; $display("FAIL dwr_addr got=%h exp=00001000", pmem_address); end
    total++; if (pmem_wdata !== wd) begin bad++; $display("FAIL dwr_wdata got=%h exp=%h", pmem_wdata, wd); end
    tick();
    pmem_resp = 1'b1;
    sample();
    total++; if (d_resp !== 1'b1 || i_resp !== 1'b0) begin bad++; $display("FAIL dwr_resp got=%b%b exp=01", i_resp, d_resp); end
    tick();
    pmem_resp = 1'b0; d_write = 1'b0;
    sample();
    total++; if (d_resp !== 1'b0 || pmem_write !== 1'b0) begin bad++; $display("FAIL dwr_release got=%b%b exp=00", d_resp, pmem_write); end
    tick();
  endtask

  // d_read and d_write together: write wins
  task automatic test_write_wins;
    d_read = 1'b1; d_write = 1'b1; d_addr = 32'h0000_2000; d_wdata = {8{32'h1234_5678}};
    tick();
    sample();
    total++; if (pmem_write !== 1'b1 || pmem_read !== 1'b0) begin bad++; $display("FAIL wwins_cmd got=%b%b exp=01", pmem_read, pmem_write); end
    tick();
    pmem_resp = 1'b1;
    sample();
    total++; if (d_resp !== 1'b1) begin bad++; $display("FAIL wwins_resp got=%b exp=1", d_resp); end
    tick();
    pmem_resp = 1'b0; d_read = 1'b0; d_write = 1'b0;
    tick();
  endtask

  // both requesters held: fresh reset, then D, I, D, I
  task automatic test_contention;
    arb_grant_t exp_last;
    arb_state_t exp_st;
    logic [AW-1:0] exp_addr;
    apply_reset();
    exp_last = GRANT_I;
    i_read = 1'b1; i_addr = 32'h0000_0080;
    d_read = 1'b1; d_addr = 32'h0000_0C00;
    for (int t = 0; t < 4; t++) begin
      exp_last = (exp_last == GRANT_I) ? GRANT_D : GRANT_I;
      exp_st   = (exp_last == GRANT_D) ? SERVE_D : SERVE_I;
      exp_addr = (exp_last == GRANT_D) ? 32'h0000_0C00 : 32'h0000_0080;
      tick();
      pmem_resp = 1'b1; pmem_rdata = {8{t[31:0]}};
      sample();
      total++; if (o_state !== exp_st) begin bad++; $display("FAIL contend_grant t=%0d got=%0d exp=%0d", t, o_state, exp_st); end
      total++; if (pmem_address !== exp_addr || pmem_read !== 1'b1) begin bad++; $display("FAIL contend_cmd t=%0d got=%h/%b exp=%h/1", t, pmem_address, pmem_read, exp_addr); end
      total++; if (i_resp !== (exp_last == GRANT_I) || d_resp !== (exp_last == GRANT_D)) begin bad++; $display("FAIL contend_resp t=%0d got=%b%b", t, i_resp, d_resp); end
      tick();
      pmem_resp = 1'b0;
      sample();
      total++; if (o_state !== RELEASE || pmem_read !== 1'b0) begin bad++; $display("FAIL contend_release t=%0d got=%0d/%b", t, o_state, pmem_read); end
      tick();
    end
    i_read = 1'b0; d_read = 1'b0;
    tick();
  endtask

  // requester changes address mid-transaction: port stays on the latched one
  task automatic test_addr_stable;
    d_read = 1'b1; d_addr = 32'h0000_0100;
    tick();
    d_addr = 32'h0000_0200;
    for (int c = 0; c < 3; c++) begin
      sample();
      total++; if (pmem_address !== 32'h100) begin bad++; $display("FAIL stable_addr c=%0d got=%h exp=00000100", c, pmem_address); end
      tick();
    end
    pmem_resp = 1'b1;
    sample();
    total++; if (pmem_address !== 32'h100 || d_resp !== 1'b1) begin bad++; $display("FAIL stable_resp got=%h/%b exp=00000100/1", pmem_address, d_resp); end
    tick();
    pmem_resp = 1'b0; d_read = 1'b0;
    tick();
  endtask

  // asynchronous reset in SERVE_D, then a stray memory response
  task automatic test_reset_mid;
    d_write = 1'b1; d_addr = 32'h0000_0300; d_wdata = {8{32'hCAFE_F00D}};
    tick();
    sample();
    total++; if (pmem_write !== 1'b1) begin bad++; $display("FAIL rstmid_pre got=%b exp=1", pmem_write); end
    #1;
    rst_n = 1'b0;
    d_write = 1'b0;
    #1;
    total++; if (pmem_write !== 1'b0 || o_state !== IDLE) begin bad++; $display("FAIL rstmid_async got=%b/%0d exp=0/%0d", pmem_write, o_state, IDLE); end
    tick();
    rst_n = 1'b1;
    pmem_resp = 1'b1;
    sample();
    total++; if (d_resp !== 1'b0 || i_resp !== 1'b0) begin bad++; $display("FAIL rstmid_stray_resp got=%b%b exp=00", i_resp, d_resp); end
    tick();
    pmem_resp = 1'b0;
    sample();
    total++; if (o_state !== IDLE) begin bad++; $display("FAIL rstmid_stay_idle got=%0d exp=%0d", o_state, IDLE); end
  endtask

  // i_read dropped early: response suppressed, pending D granted next
  task automatic test_drop;
    i_read = 1'b1; i_addr = 32'h0000_0400;
    tick();
    i_read = 1'b0;
    d_read = 1'b1; d_addr = 32'h0000_0500;
    sample();
    total++; if (o_state !== SERVE_I) begin bad++; $display("FAIL drop_serve got=%0d exp=%0d", o_state, SERVE_I); end
    tick();
    pmem_resp = 1'b1;
    sample();
    total++; if (i_resp !== 1'b0 || d_resp !== 1'b0) begin bad++; $display("FAIL drop_suppressed got=%b%b exp=00", i_resp, d_resp); end
    tick();
    pmem_resp = 1'b0;
    sample();
    total++; if (o_state !== RELEASE) begin bad++; $display("FAIL drop_release got=%0d exp=%0d", o_state, RELEASE); end
    tick();
    sample();
    total++; if (o_state !== IDLE) begin bad++; $display("FAIL drop_idle got=%0d exp=%0d", o_state, IDLE); end
    tick();
    pmem_resp = 1'b1;
    sample();
    total++; if (o_state !== SERVE_D || pmem_address !== 32'h500 || pmem_read !== 1'b1) begin bad++; $display("FAIL drop_next_d got=%0d/%h/%b exp=%0d/00000500/1", o_state, pmem_address, pmem_read, SERVE_D); end
    total++; if (d_resp !== 1'b1) begin bad++; $display("FAIL drop_next_resp got=%b exp=1", d_resp); end
    tick();
    pmem_resp = 1'b0; d_read = 1'b0;
    tick();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    clear_inputs();
    test_reset();
    test_i_read();
    test_d_write();
    test_write_wins();
    test_contention();
    test_addr_stable();
    test_reset_mid();
    test_drop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
